uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 16, meaning clocks per serial bit, legal values >= 4.
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data_o  output  8  received byte.
REQ-006 SHALL have port valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-007 SHALL have port ready_i  input  1  consumer accepts the byte.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse when a bad stop bit is detected.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port busy_o  output  1  receiver is not in IDLE.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized line (rxs).
REQ-012 SHALL frame data as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLK_PER_BIT clocks.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 SHALL use a bit-period counter of width $clog2(CLK_PER_BIT)+1 and a 3-bit data-bit index.
REQ-015 IDLE: rxs==0 -> START, counter cleared.
REQ-016 START: at counter==CLK_PER_BIT/2-1 (integer division), sample rxs. 0 -> DATA, counter and index cleared. 1 -> IDLE as a glitch, with no output or flag.
REQ-017 DATA: at counter==CLK_PER_BIT-1, sample rxs into shift bit [index] and clear counter. Index 7 -> STOP, otherwise index+1.
REQ-018 STOP: at counter==CLK_PER_BIT-1, sample rxs. 1 -> byte complete, IDLE. 0 -> frame_err_o high for exactly that next cycle, byte discarded, WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rxs==1, then IDLE, so a break/stuck-low line yields one error only.
REQ-020 On byte complete, rx_data_o and valid_o SHALL update on the same edge that leaves STOP.
REQ-021 Transfer occurs when valid_o && ready_i; valid_o SHALL then clear next cycle unless a new byte completes that cycle.
REQ-022 rx_data_o SHALL remain stable while valid_o==1 and no transfer occurs.
REQ-023 Byte complete with valid_o==1, ready_i==0: overrun_o pulses one cycle, new byte dropped, old byte and valid_o retained.
REQ-024 Byte complete with valid_o==1, ready_i==1 in the same cycle: old byte transfers, new byte loads, valid_o stays 1, no overrun.
REQ-025 ready_i while valid_o==0 SHALL have no effect.
REQ-026 busy_o SHALL be combinational: high in any state except IDLE.
REQ-027 Reception SHALL never stall on ready_i; the output register is the only buffering.

Reset
REQ-028 rst_i=1 SHALL force:
- state IDLE
- synchronizer flops 1
- counter, index, shift register 0
- rx_data_o 0x00
- valid_o, frame_err_o, overrun_o 0
REQ-029 Reset mid-frame SHALL abort the frame with no partial byte, flag or valid.
REQ-030 Reset SHALL discard any pending valid byte.
REQ-031 The first start edge SHALL be detectable on the first cycle after rst_i deasserts (given the 2-cycle sync latency).

Verification (CLK_PER_BIT=16)
REQ-032 Frame 0xA5, ready_i=1 -> valid_o high 1 cycle, rx_data_o=0xA5, no flags.
REQ-033 rx_i low 4 clocks then high -> returns IDLE; valid_o, frame_err_o stay 0; busy_o low again within 12 clocks.
REQ-034 Byte 0x3C with stop bit 0, line low 40 clocks then frame 0x5A -> one frame_err_o pulse, no valid for 0x3C, then rx_data_o=0x5A valid.
REQ-035 Back-to-back 0x11, 0x22, ready_i=0 -> overrun_o one pulse at 0x22 completion, rx_data_o=0x11. Then ready_i=1 -> one transfer of 0x11, valid_o low.
REQ-036 0x11 pending, ready_i=1 exactly on 0x22 completion cycle -> 0x11 transferred, rx_data_o=0x22, valid_o=1, overrun_o=0.
REQ-037 rst_i pulsed during data bit 4 of 0x7E -> all outputs 0, no valid. Following frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer and single-entry output register
// Ports: clk_i/rst_i clock and sync active-high reset; rx_i serial line (idle high);
// rx_data_o/valid_o/ready_i byte handshake; frame_err_o bad stop pulse;
// overrun_o dropped byte pulse; busy_o receiver not idle.
module uart_rx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic [7:0] rx_data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        state_q;
  logic          s1_q, rxs_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_o   <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      s1_q        <= rx_i;
      rxs_q       <= s1_q;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      // a completing byte below overrides this clear when both happen together
      if (valid_o && ready_i) valid_o <= 1'b0;
      case (state_q)
        IDLE: if (!rxs_q) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= rxs_q ? IDLE : DATA;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == FULL) begin
          cnt_q          <= '0;
          shift_q[idx_q] <= rxs_q;
          idx_q          <= idx_q + 1'b1;
          if (idx_q == 3'd7) state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (cnt_q == FULL) begin
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= IDLE;
            if (!valid_o || ready_i) begin
              rx_data_o <= shift_q;
              valid_o   <= 1'b1;
            end else overrun_o <= 1'b1;
          end else begin
            frame_err_o <= 1'b1;
            state_q     <= WAIT_HIGH;
          end
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_HIGH: if (rxs_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
